maxpool_engine: RTL and testbench

Max-pooling layer engine: the responder side of the layer sequencer's start/finish handshake. It latches a layer configuration on a `start` pulse and reads 8-bit signed feature maps from the shared single-port BRAM. It computes the maximum of each dkr×dkc window at stride `step`, writes the results back to the BRAM, and pulses `picture_finish` when the layer is complete. It sits beside the convolution controller and shares the same memory port through the top-level mux, which grants the port to this block while `busy` is high.

---
 rtl/maxpool_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_maxpool_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_engine.sv
// ============================================================================
//  maxpool_engine
//  Max-pooling layer engine: reads signed feature maps from the shared BRAM,
//  writes the maximum of every dkr x dkc window back. Optional macro: MP_RELU_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_engine #(
  parameter int WIDTH      = 8,
  parameter int MEMADDRBIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MEMADDRBIT-1:0] di,
  input  logic [MEMADDRBIT-1:0] dr,
  input  logic [MEMADDRBIT-1:0] dc,
  input  logic [MEMADDRBIT-1:0] dkr,
  input  logic [MEMADDRBIT-1:0] dkc,
  input  logic [MEMADDRBIT-1:0] dr_out,
  input  logic [MEMADDRBIT-1:0] dc_out,
  input  logic [2:0]            step,
  input  logic [MEMADDRBIT-1:0] inaddr,
  input  logic [MEMADDRBIT-1:0] outaddr,
  output logic [MEMADDRBIT-1:0] mem_addr,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  picture_finish
);

  localparam logic [MEMADDRBIT-1:0] c_one = MEMADDRBIT'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LAST  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;

  logic [MEMADDRBIT-1:0] r_di, r_dr, r_dc, r_dkr, r_dkc, r_dro, r_dco, r_step;
  logic [MEMADDRBIT-1:0] r_inaddr, r_outaddr;
  logic [MEMADDRBIT-1:0] r_ii, r_or, r_oc, r_kr, r_kc;
  logic signed [WIDTH-1:0] r_acc;
  logic r_vld, r_vfirst;
  logic [MEMADDRBIT-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [WIDTH-1:0]      r_mem_wdata;
  logic                  r_busy, r_finish;

  logic w_kc_wrap, w_win_last, w_oc_wrap, w_or_wrap, w_ii_wrap, w_out_last;
  logic w_degenerate;
  logic [MEMADDRBIT-1:0] w_nkr, w_nkc, w_noc, w_nor, w_nii;
  logic [MEMADDRBIT-1:0] w_a_ii, w_a_or, w_a_oc, w_a_kr, w_a_kc;
  logic [MEMADDRBIT-1:0] w_row, w_col, w_rd_addr, w_wr_addr;
  logic signed [WIDTH-1:0] w_sample, w_acc_next, w_wval;

  assign w_degenerate = (di == '0) || (dr_out == '0) || (dc_out == '0) ||
                        (dkr == '0) || (dkc == '0);

  assign w_kc_wrap  = (r_kc == r_dkc - c_one);
  assign w_win_last = (r_kr == r_dkr - c_one) && w_kc_wrap;
  assign w_oc_wrap  = (r_oc == r_dco - c_one);
  assign w_or_wrap  = (r_or == r_dro - c_one);
  assign w_ii_wrap  = (r_ii == r_di - c_one);
  assign w_out_last = w_ii_wrap && w_or_wrap && w_oc_wrap;

  assign w_nkr = w_kc_wrap ? r_kr + c_one : r_kr;
  assign w_nkc = w_kc_wrap ? '0 : r_kc + c_one;
  assign w_noc = w_oc_wrap ? '0 : r_oc + c_one;
  assign w_nor = w_oc_wrap ? (w_or_wrap ? '0 : r_or + c_one) : r_or;
  assign w_nii = (w_oc_wrap && w_or_wrap) ? r_ii + c_one : r_ii;

  // One shared read-address unit: WRITE looks ahead to the next output's
  // first window element, READ looks ahead to the next element of this window.
  always_comb begin
    w_a_ii = r_ii;
    w_a_or = r_or;
    w_a_oc = r_oc;
    w_a_kr = w_nkr;
    w_a_kc = w_nkc;
    if (r_state == S_WRITE) begin
      w_a_ii = w_nii;
      w_a_or = w_nor;
      w_a_oc = w_noc;
      w_a_kr = '0;
      w_a_kc = '0;
    end
  end

  assign w_row     = w_a_or * r_step + w_a_kr;
  assign w_col     = w_a_oc * r_step + w_a_kc;
  assign w_rd_addr = r_inaddr + (w_a_ii * r_dr + w_row) * r_dc + w_col;
  assign w_wr_addr = r_outaddr + (r_ii * r_dro + r_or) * r_dco + r_oc;

  assign w_sample   = $signed(mem_rdata);
  assign w_acc_next = (r_vfirst || (w_sample > r_acc)) ? w_sample : r_acc;

`ifdef MP_RELU_EN
  assign w_wval = w_acc_next[WIDTH-1] ? '0 : w_acc_next;
`else
  assign w_wval = w_acc_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_di        <= '0;
      r_dr        <= '0;
      r_dc        <= '0;
      r_dkr       <= '0;
      r_dkc       <= '0;
      r_dro       <= '0;
      r_dco       <= '0;
      r_step      <= '0;
      r_inaddr    <= '0;
      r_outaddr   <= '0;
      r_ii        <= '0;
      r_or        <= '0;
      r_oc        <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_acc       <= '0;
      r_vld       <= 1'b0;
      r_vfirst    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      // Read data returns one cycle after its address was issued in READ.
      r_vld    <= (r_state == S_READ);
      r_vfirst <= (r_state == S_READ) && (r_kr == '0) && (r_kc == '0);
      if (r_vld) r_acc <= w_acc_next;
      r_mem_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_mem_addr <= '0;
          if (start) begin
            r_di      <= di;
            r_dr      <= dr;
            r_dc      <= dc;
            r_dkr     <= dkr;
            r_dkc     <= dkc;
            r_dro     <= dr_out;
            r_dco     <= dc_out;
            r_step    <= {{(MEMADDRBIT-3){1'b0}}, step};
            r_inaddr  <= inaddr;
            r_outaddr <= outaddr;
            r_ii      <= '0;
            r_or      <= '0;
            r_oc      <= '0;
            r_kr      <= '0;
            r_kc      <= '0;
            r_busy    <= 1'b1;
            if (w_degenerate) begin
              r_state  <= S_DONE;
              r_finish <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_mem_addr <= inaddr;
            end
          end
        end
        S_READ: begin
          if (w_win_last) begin
            r_state <= S_LAST;
          end else begin
            r_kr       <= w_nkr;
            r_kc       <= w_nkc;
            r_mem_addr <= w_rd_addr;
          end
        end
        S_LAST: begin
          r_state     <= S_WRITE;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_wr_addr;
          r_mem_wdata <= w_wval;
        end
        S_WRITE: begin
          if (w_out_last) begin
            r_state    <= S_DONE;
            r_mem_addr <= '0;
          end else begin
            r_state    <= S_READ;
            r_ii       <= w_nii;
            r_or       <= w_nor;
            r_oc       <= w_noc;
            r_kr       <= '0;
            r_kc       <= '0;
            r_mem_addr <= w_rd_addr;
          end
        end
        S_DONE: begin
          // The pulse is raised once; the following cycle drops busy as well.
          if (r_finish) begin
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_finish <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr       = r_mem_addr;
  assign mem_we         = r_mem_we;
  assign mem_wdata      = r_mem_wdata;
  assign busy           = r_busy;
  assign picture_finish = r_finish;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_engine.sv
// ============================================================================
//  tb_maxpool_engine
//  Scoreboard bench for maxpool_engine with a registered-read BRAM model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [16:0] di = '0, dr = '0, dc = '0, dkr = '0, dkc = '0;
  logic [16:0] dr_out = '0, dc_out = '0, inaddr = '0, outaddr = '0;
  logic [2:0]  step = '0;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        busy;
  logic        picture_finish;

  logic [7:0] mem [0:(1<<17)-1];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [16:0] exp_a[$];
  logic [7:0]  exp_d[$];
  int          exp_fin[$];

  maxpool_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .di(di), .dr(dr), .dc(dc), .dkr(dkr), .dkc(dkc),
    .dr_out(dr_out), .dc_out(dc_out), .step(step),
    .inaddr(inaddr), .outaddr(outaddr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .picture_finish(picture_finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every finish pulse is matched against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && mem_we) begin
        if (exp_a.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", mem_addr, mem_wdata);
        end else begin
          chk("write_addr", 32'(mem_addr), 32'(exp_a.pop_front()));
          chk("write_data", 32'(mem_wdata), 32'(exp_d.pop_front()));
        end
      end
      if (rst && picture_finish) begin
        if (exp_fin.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_finish: got pulse at cycle %0d expected none", cyc);
        end else begin
          chk("finish_cycle", 32'(cyc), 32'(exp_fin.pop_front()));
        end
      end
    end
  end

  task automatic set_cfg(input int a_di, a_dr, a_dc, a_dkr, a_dkc, a_dro, a_dco,
                         input int a_st, a_in, a_out);
    di = 17'(a_di); dr = 17'(a_dr); dc = 17'(a_dc); dkr = 17'(a_dkr); dkc = 17'(a_dkc);
    dr_out = 17'(a_dro); dc_out = 17'(a_dco); step = 3'(a_st);
    inaddr = 17'(a_in); outaddr = 17'(a_out);
  endtask

  // Start is high during cycle t0; returns at the negedge of cycle t0+1.
  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Golden window-max model over the bench memory, first `limit` outputs.
  task automatic model(input int limit);
    int cnt = 0;
    for (int ii = 0; ii < int'(di); ii++)
      for (int ro = 0; ro < int'(dr_out); ro++)
        for (int co = 0; co < int'(dc_out); co++) begin
          logic signed [7:0] mx;
          mx = 0;
          for (int kr = 0; kr < int'(dkr); kr++)
            for (int kc = 0; kc < int'(dkc); kc++) begin
              logic [16:0] a;
              logic signed [7:0] v;
              a = 17'(int'(inaddr) + (ii*int'(dr) + ro*int'(step) + kr)*int'(dc)
                      + co*int'(step) + kc);
              v = $signed(mem[a]);
              if ((kr == 0 && kc == 0) || v > mx) mx = v;
            end
`ifdef MP_RELU_EN
          if (mx < 0) mx = 0;
`endif
          if (cnt < limit) begin
            exp_a.push_back(17'(int'(outaddr) + (ii*int'(dr_out) + ro)*int'(dc_out) + co));
            exp_d.push_back(mx);
          end
          cnt++;
        end
  endtask

  task automatic push_ramp_exp(input int t0);
    exp_a.push_back(17'd200); exp_d.push_back(8'd5);
    exp_a.push_back(17'd201); exp_d.push_back(8'd7);
    exp_a.push_back(17'd202); exp_d.push_back(8'd13);
    exp_a.push_back(17'd203); exp_d.push_back(8'd15);
    exp_fin.push_back(t0 + 26);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_fin.size() != 0 || exp_a.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_fin.size() != 0 || exp_a.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d writes and %0d finishes outstanding expected 0",
               name, exp_a.size(), exp_fin.size());
      exp_a.delete(); exp_d.delete(); exp_fin.delete();
    end
    repeat (3) @(negedge clk);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 16; i++) mem[100 + i] = 8'(i);
    mem[300] = 8'hFD; mem[301] = 8'h80; mem[302] = 8'hFF; mem[303] = 8'hF9;
    for (int i = 0; i < 1152; i++) mem[1061 + i] = 8'($urandom_range(0, 255));

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(picture_finish), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1x4x4 ramp, 2x2 window, stride 2
    set_cfg(1, 4, 4, 2, 2, 2, 2, 2, 100, 200);
    @(negedge clk);
    push_ramp_exp(cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_read_addr", 32'(mem_addr), 32'd100);
    chk("busy_cycle1", 32'(busy), 32'd1);
    wait_drain("ramp", 100);

    // All-negative window
    set_cfg(1, 2, 2, 2, 2, 1, 1, 1, 300, 400);
    exp_a.push_back(17'd400);
`ifdef MP_RELU_EN
    exp_d.push_back(8'h00);
`else
    exp_d.push_back(8'hFF);
`endif
    @(negedge clk);
    exp_fin.push_back(cyc + 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("negwin", 50);

    // Full layer 8x12x12 against the golden model
    set_cfg(8, 12, 12, 2, 2, 6, 6, 2, 1061, 2213);
    model(288);
    @(negedge clk);
    exp_fin.push_back(cyc + 1730);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("full", 2000);

    // Second start mid-layer with a different configuration must be ignored
    set_cfg(1, 4, 4, 2, 2, 2, 2, 2, 100, 200);
    @(negedge clk);
    push_ramp_exp(cyc);
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_cfg(1, 4, 4, 1, 1, 4, 4, 1, 0, 600);
    while (cyc < t0 + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("restart", 100);

    // Degenerate layer: dkr = 0
    set_cfg(1, 4, 4, 0, 2, 2, 2, 2, 100, 200);
    @(negedge clk);
    exp_fin.push_back(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("degen_busy_c1", 32'(busy), 32'd1);
    chk("degen_addr_c1", 32'(mem_addr), 32'd0);
    @(negedge clk);
    chk("degen_busy_c2", 32'(busy), 32'd0);
    wait_drain("degen", 20);

    // Reset at cycle 50 of a full layer: only the first 8 writes may appear
    set_cfg(8, 12, 12, 2, 2, 6, 6, 2, 1061, 2213);
    model(8);
    pulse_start(t0);
    while (cyc < t0 + 50) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("midrst_finish", 32'(picture_finish), 32'd0);
    chk("midrst_writes_left", 32'(exp_a.size()), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Normal layer after the reset
    set_cfg(1, 4, 4, 2, 2, 2, 2, 2, 100, 200);
    @(negedge clk);
    push_ramp_exp(cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("postrst", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
